// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Stall/flush sequencer for the 5-stage MiniMIPS32 pipeline.
//  - Merges ID/EX/MEM stall requests into one 6-bit stall vector. The highest
//    requesting stage wins, and every stage upstream of it is stopped too.
//  - Runs a two-cycle redirect for exceptions and ERET. The first cycle freezes
//    the whole pipe. The second cycle flushes every stage and presents the new PC.
//  - Raises an internal bus-timeout exception when MEM waits for too long.
//  - Counts the cycles in which any stage is stalled.
//
// Ports
//  clk           in   clock
//  rst           in   asynchronous reset, active-low
//  stallreq_id   in   ID stall request (load-use)
//  stallreq_ex   in   EX stall request (mul/div busy)
//  stallreq_mem  in   MEM stall request (bus wait)
//  exc_code_i    in   exception code of the instruction in MEM
//  epc_i         in   CP0 EPC, the ERET target
//  stall         out  [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB, 1 = stop (combinational)
//  flush         out  clears all stage registers to bubbles (combinational)
//  new_pc        out  redirect target, valid while flush = 1
//  exc_code_o    out  code being serviced, valid while flush = 1
//  stall_cnt     out  saturating count of cycles with stall != 0 (registered)
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int unsigned                EXC_CODE_WIDTH = 5,
    parameter logic [EXC_CODE_WIDTH-1:0]  EC_NONE        = EXC_CODE_WIDTH'(0),
    parameter logic [EXC_CODE_WIDTH-1:0]  EC_ERET        = EXC_CODE_WIDTH'(5'h1F),
    parameter logic [EXC_CODE_WIDTH-1:0]  EC_BUS_TIMEOUT = EXC_CODE_WIDTH'(5'h07),
    parameter logic [31:0]                EXC_VECTOR     = 32'hBFC00380,
    parameter int unsigned                TIMEOUT        = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stallreq_id,
    input  logic                      stallreq_ex,
    input  logic                      stallreq_mem,
    input  logic [EXC_CODE_WIDTH-1:0] exc_code_i,
    input  logic [31:0]               epc_i,
    output logic [5:0]                stall,
    output logic                      flush,
    output logic [31:0]               new_pc,
    output logic [EXC_CODE_WIDTH-1:0] exc_code_o,
    output logic [31:0]               stall_cnt
);

    // The timer is at least 8 bits wide, and wider when TIMEOUT needs more bits.
    localparam int unsigned TMR_BITS = $clog2(TIMEOUT + 1);
    localparam int unsigned TMR_W    = (TMR_BITS > 8) ? TMR_BITS : 8;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT);

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FREEZE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_e;

    state_e                      state_q, state_d;
    logic [EXC_CODE_WIDTH-1:0]   code_q, code_d;
    logic [31:0]                 target_q, target_d;
    logic [TMR_W-1:0]            timer_q, timer_d;
    logic [31:0]                 stall_cnt_q, stall_cnt_d;

    logic                        exc_seen;
    logic                        timeout_hit;
    logic [EXC_CODE_WIDTH-1:0]   accept_code;

    // State and latched-redirect registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            code_q      <= EC_NONE;
            target_q    <= '0;
            timer_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            code_q      <= code_d;
            target_q    <= target_d;
            timer_q     <= timer_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign exc_seen    = (exc_code_i != EC_NONE);
    assign timeout_hit = (timer_q == TMR_MAX);
    // A real exception takes priority over a timeout raised in the same cycle.
    assign accept_code = exc_seen ? exc_code_i : EC_BUS_TIMEOUT;

    // Next-state and output logic
    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        target_d   = target_q;
        timer_d    = '0;
        stall      = STALL_NONE;
        flush      = 1'b0;
        new_pc     = '0;
        exc_code_o = EC_NONE;

        // While reset is held, all outputs stay at zero, whatever the inputs.
        if (rst) begin
            unique case (state_q)
                ST_RUN: begin
                    if (exc_seen || timeout_hit) begin
                        stall    = STALL_ALL;
                        code_d   = accept_code;
                        target_d = (accept_code == EC_ERET) ? epc_i : EXC_VECTOR;
                        state_d  = ST_FREEZE;
                    end else begin
                        if (stallreq_mem) begin
                            stall = STALL_MEM;
                        end else if (stallreq_ex) begin
                            stall = STALL_EX;
                        end else if (stallreq_id) begin
                            stall = STALL_ID;
                        end
                        // This count measures consecutive MEM wait cycles.
                        // It restarts whenever MEM stops requesting a stall.
                        if (stallreq_mem) begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                end
                // Stall requests in these two states come from squashed
                // instructions, so they are ignored.
                ST_FREEZE: begin
                    stall   = STALL_ALL;
                    state_d = ST_FLUSH;
                end
                ST_FLUSH: begin
                    flush      = 1'b1;
                    new_pc     = target_q;
                    exc_code_o = code_q;
                    state_d    = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    // Saturating stall-cycle counter
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall != STALL_NONE) && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl. The driver pushes one hand-computed
// expectation for each cycle it drives. The monitor pops these expectations
// and compares them with the DUT outputs, sampled mid-cycle on the falling edge.
module tb_pipeline_ctrl;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic [4:0]  exc_code_i;
    logic [31:0] epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [4:0]  exc_code_o;
    logic [31:0] stall_cnt;

    pipeline_ctrl #(
        .EXC_CODE_WIDTH (5),
        .EC_NONE        (5'h00),
        .EC_ERET        (5'h1F),
        .EC_BUS_TIMEOUT (5'h07),
        .EXC_VECTOR     (32'hBFC00380),
        .TIMEOUT        (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_code_i   (exc_code_i),
        .epc_i        (epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .exc_code_o   (exc_code_o),
        .stall_cnt    (stall_cnt)
    );

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [4:0]  code;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [31:0] exp_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the expected outputs for that cycle.
    task automatic vec(input string nm, input logic r, input logic id, input logic ex,
                       input logic mem, input logic [4:0] exc, input logic [31:0] epc,
                       input logic [5:0] s, input logic f, input logic [31:0] pc,
                       input logic [4:0] c);
        exp_t e;
        @(posedge clk);
        #1;
        rst          = r;
        stallreq_id  = id;
        stallreq_ex  = ex;
        stallreq_mem = mem;
        exc_code_i   = exc;
        epc_i        = epc;
        if (!r) exp_cnt = 0;
        e.name  = nm;
        e.stall = s;
        e.flush = f;
        e.pc    = pc;
        e.code  = c;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        if (r && (s != 6'b0) && (exp_cnt != 32'hFFFF_FFFF)) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic idle(input string nm);
        vec(nm, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000000, 1'b0, 32'h0, 5'h00);
    endtask

    // Monitor: compare each mid-cycle sample against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            if (stall !== e.stall) begin
                n_miss++;
                $display("FAIL %s stall: got %b want %b", e.name, stall, e.stall);
            end
            if (flush !== e.flush) begin
                n_miss++;
                $display("FAIL %s flush: got %b want %b", e.name, flush, e.flush);
            end
            if (new_pc !== e.pc) begin
                n_miss++;
                $display("FAIL %s new_pc: got %h want %h", e.name, new_pc, e.pc);
            end
            if (exc_code_o !== e.code) begin
                n_miss++;
                $display("FAIL %s exc_code_o: got %h want %h", e.name, exc_code_o, e.code);
            end
            if (stall_cnt !== e.cnt) begin
                n_miss++;
                $display("FAIL %s stall_cnt: got %0d want %0d", e.name, stall_cnt, e.cnt);
            end
        end
    end

    initial begin
        rst          = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        exc_code_i   = 5'h00;
        epc_i        = 32'h0;

        // Reset state
        vec("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000000, 1'b0, 32'h0, 5'h00);
        vec("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 5'h04, 32'h0, 6'b000000, 1'b0, 32'h0, 5'h00);
        idle("post_reset");

        // 1: ID stall for two cycles; the stall counter should reach 2
        vec("id_a", 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000111, 1'b0, 32'h0, 5'h00);
        vec("id_b", 1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000111, 1'b0, 32'h0, 5'h00);
        idle("id_done");

        // 2: stall priority
        vec("all3",  1'b1, 1'b1, 1'b1, 1'b1, 5'h00, 32'h0, 6'b011111, 1'b0, 32'h0, 5'h00);
        vec("ex",    1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 32'h0, 6'b001111, 1'b0, 32'h0, 5'h00);
        vec("id_ex", 1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 32'h0, 6'b001111, 1'b0, 32'h0, 5'h00);
        idle("prio_done");

        // 3: exception 04; inputs during FREEZE/FLUSH are ignored
        vec("exc_acc",    1'b1, 1'b0, 1'b0, 1'b1, 5'h04, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("exc_freeze", 1'b1, 1'b1, 1'b0, 1'b0, 5'h03, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("exc_flush",  1'b1, 1'b0, 1'b0, 1'b1, 5'h05, 32'h0, 6'b000000, 1'b1, 32'hBFC00380, 5'h04);
        idle("exc_done");

        // 4: ERET uses the EPC value latched at accept
        vec("eret_acc",    1'b1, 1'b0, 1'b0, 1'b0, 5'h1F, 32'h80001234, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("eret_freeze", 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h00000000, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("eret_flush",  1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'hDEADBEEF, 6'b000000, 1'b1, 32'h80001234, 5'h1F);
        idle("eret_done");

        // 5: MEM wait timeout after TIMEOUT=4 cycles
        for (int i = 0; i < 4; i++)
            vec("tmo_wait", 1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b011111, 1'b0, 32'h0, 5'h00);
        vec("tmo_acc",    1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("tmo_freeze", 1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("tmo_flush",  1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b000000, 1'b1, 32'hBFC00380, 5'h07);
        vec("tmo_restart",1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b011111, 1'b0, 32'h0, 5'h00);
        idle("tmo_done");

        // A gap in MEM requests restarts the timer
        for (int i = 0; i < 3; i++)
            vec("gap_pre", 1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b011111, 1'b0, 32'h0, 5'h00);
        idle("gap");
        for (int i = 0; i < 4; i++)
            vec("gap_post", 1'b1, 1'b0, 1'b0, 1'b1, 5'h00, 32'h0, 6'b011111, 1'b0, 32'h0, 5'h00);

        // A real exception wins over a timeout in the same cycle (timer == 4 here)
        vec("race_acc",    1'b1, 1'b0, 1'b0, 1'b1, 5'h02, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("race_freeze", 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("race_flush",  1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000000, 1'b1, 32'hBFC00380, 5'h02);
        idle("race_done");

        // 6: reset during FREEZE drops the pending redirect
        vec("rfz_acc",   1'b1, 1'b0, 1'b0, 1'b0, 5'h04, 32'h0, 6'b111111, 1'b0, 32'h0, 5'h00);
        vec("rfz_reset", 1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000000, 1'b0, 32'h0, 5'h00);
        idle("rfz_run0");
        idle("rfz_run1");
        vec("rfz_id",    1'b1, 1'b1, 1'b0, 1'b0, 5'h00, 32'h0, 6'b000111, 1'b0, 32'h0, 5'h00);
        idle("rfz_end");

        // Wait (bounded) for the monitor to drain the scoreboard
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
